// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: instruction fetch front end with a small prefetch FIFO.
//
// One instruction-memory read is outstanding at a time. Returned words are
// queued with their PC and handed to the core in address order. A redirect
// flushes the queue, retargets fetch_pc, and drops any outstanding
// request's data when it returns.
//
// Optional feature: define FETCH_STATS_EN to add the stall_count output.
// It counts cycles where the core is ready but no instruction is
// available, and saturates at all ones.
//
// Ports:
//   clock, reset                 : single clock, async active-high reset
//   imem_req, imem_addr          : read request and word-aligned byte address
//   imem_ack, imem_rdata         : read completion and returned word
//   instr_valid, instr, instr_pc : head of the prefetch FIFO
//   instr_ready                  : core consumes the head this cycle
//   redirect, redirect_pc        : taken branch/jump and its target
//   stall_count                  : (FETCH_STATS_EN only) stall cycle count
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stall_count
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t           state_r;
  logic [31:0]      fetch_pc_r;
  logic [31:0]      fifo_pc_r   [FIFO_DEPTH];
  logic [31:0]      fifo_data_r [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;

  logic             push_s;
  logic             pop_s;
  logic             issue_s;
  logic             not_empty_s;
  logic [31:0]      redirect_target_s;

  // Handshake decodes; redirect suppresses push, pop and issue.
  always_comb begin
    not_empty_s       = (count_r != {CNT_W{1'b0}});
    push_s            = (state_r == ST_WAIT) && imem_ack && !redirect;
    pop_s             = not_empty_s && instr_ready && !redirect;
    issue_s           = (state_r == ST_IDLE) && (count_r < DEPTH_C) && !redirect;
    redirect_target_s = redirect_pc & 32'hFFFF_FFFC;
  end

  // Core-facing outputs come straight from the FIFO head registers.
  always_comb begin
    instr_valid = not_empty_s;
    instr       = fifo_data_r[rd_ptr_r];
    instr_pc    = fifo_pc_r[rd_ptr_r];
  end

  // Request state machine: owns fetch_pc and the registered memory request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      fetch_pc_r <= RESET_PC;
      imem_req   <= 1'b0;
      imem_addr  <= RESET_PC;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // An ack seen here belongs to an abandoned request and is ignored.
          if (redirect) begin
            fetch_pc_r <= redirect_target_s;
          end else if (issue_s) begin
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc_r;
            state_r   <= ST_WAIT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (imem_ack) begin
            imem_req   <= 1'b0;
            state_r    <= ST_IDLE;
            fetch_pc_r <= redirect ? redirect_target_s : (fetch_pc_r + 32'd4);
          end else if (redirect) begin
            // Request stays on the bus; its data is thrown away on return.
            state_r    <= ST_DROP;
            fetch_pc_r <= redirect_target_s;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_DROP: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            state_r  <= ST_IDLE;
          end else begin
            state_r <= ST_DROP;
          end
          if (redirect) begin
            fetch_pc_r <= redirect_target_s;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  // Prefetch FIFO storage, pointers and occupancy; redirect empties it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc_r[i]   <= 32'h0000_0000;
        fifo_data_r[i] <= 32'h0000_0000;
      end
    end else if (redirect) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        fifo_pc_r[wr_ptr_r]   <= imem_addr;
        fifo_data_r[wr_ptr_r] <= imem_rdata;
        wr_ptr_r              <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] stall_count_r;

  // Saturating count of cycles where the core waits on an empty FIFO.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count_r <= 32'h0000_0000;
    end else if (instr_ready && !not_empty_s && (stall_count_r != 32'hFFFF_FFFF)) begin
      stall_count_r <= stall_count_r + 32'd1;
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign stall_count = stall_count_r;
`endif

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Scoreboard bench for mips_fetch_unit. The stimulus process queues
// expected {pc, word} pairs; a monitor pops and compares on every
// instr_valid && instr_ready handshake. dut uses RESET_PC=0, depth 4,
// memory word n = 32'h1000_0000+n. dut2 uses RESET_PC=32'hFFFF_FFF8,
// depth 2, and returns the bitwise inverse of the address.
module tb_mips_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req,  imem_ack,  instr_valid,  instr_ready,  redirect;
  logic [31:0] imem_addr, imem_rdata, instr, instr_pc, redirect_pc;
  logic        imem_req2, imem_ack2, instr_valid2, instr_ready2, redirect2;
  logic [31:0] imem_addr2, imem_rdata2, instr2, instr_pc2, redirect_pc2;
`ifdef FETCH_STATS_EN
  logic [31:0] stall_count, stall_count2;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t q[$];
  exp_t q2[$];
  int   vectors   = 0;
  int   errors    = 0;
  int   req_count = 0;
  int   ack_delay = 0;
  int   wait_cnt  = 0;
  logic mem_stall = 1'b0;
  logic force_ack = 1'b0;

  always #5 clock = ~clock;

  mips_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef FETCH_STATS_EN
    , .stall_count(stall_count)
`endif
  );

  mips_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut2 (
    .clock(clock), .reset(reset),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack2), .imem_rdata(imem_rdata2),
    .instr_valid(instr_valid2), .instr(instr2), .instr_pc(instr_pc2), .instr_ready(instr_ready2),
    .redirect(redirect2), .redirect_pc(redirect_pc2)
`ifdef FETCH_STATS_EN
    , .stall_count(stall_count2)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic wait_req(input logic level, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (imem_req === level) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    if (!ok) begin
      vectors++;
      errors++;
      $display("FAIL %s: imem_req never reached %0b, got %0b", name, level, imem_req);
    end
  endtask

  // Raise ready until the chosen scoreboard queue empties, then drop it.
  task automatic drain(input int sel, input int budget, input string name);
    bit done = 1'b0;
    if (sel == 0) instr_ready = 1'b1; else instr_ready2 = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (((sel == 0) ? q.size() : q2.size()) == 0) begin
        done = 1'b1;
        break;
      end
      tick(1);
    end
    if (!done) begin
      vectors++;
      errors++;
      $display("FAIL %s: %0d expected instructions never delivered, got none, expected all",
               name, (sel == 0) ? q.size() : q2.size());
      if (sel == 0) q.delete(); else q2.delete();
    end
    if (sel == 0) instr_ready = 1'b0; else instr_ready2 = 1'b0;
  endtask

  // Memory model for dut: word n at byte address 4n, optional ack delay.
  initial begin : mem1
    imem_ack   = 1'b0;
    imem_rdata = 32'h0000_0000;
    forever begin
      @(posedge clock);
      #1;
      if (force_ack) begin
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        wait_cnt   = 0;
      end else if (imem_req && !mem_stall) begin
        if (wait_cnt >= ack_delay) begin
          imem_ack   = 1'b1;
          imem_rdata = 32'h1000_0000 + (imem_addr >> 2);
          wait_cnt   = 0;
        end else begin
          imem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        imem_ack = 1'b0;
        if (!imem_req) wait_cnt = 0;
      end
    end
  end

  // Memory model for dut2: immediate ack, data is the inverted address.
  initial begin : mem2
    imem_ack2   = 1'b0;
    imem_rdata2 = 32'h0000_0000;
    forever begin
      @(posedge clock);
      #1;
      if (imem_req2) begin
        imem_ack2   = 1'b1;
        imem_rdata2 = ~imem_addr2;
      end else begin
        imem_ack2 = 1'b0;
      end
    end
  end

  // Monitor: compare every handshake against the scoreboard heads.
  initial begin : mon
    exp_t e;
    logic prev_req;
    prev_req = 1'b0;
    forever begin
      @(negedge clock);
      if (instr_valid && instr_ready) begin
        if (q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL dut_unexpected: got pc %h instr %h, expected no delivery", instr_pc, instr);
        end else begin
          e = q.pop_front();
          check("dut_instr_pc", instr_pc, e.pc);
          check("dut_instr", instr, e.word);
        end
      end
      if (instr_valid2 && instr_ready2) begin
        if (q2.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL dut2_unexpected: got pc %h instr %h, expected no delivery", instr_pc2, instr2);
        end else begin
          e = q2.pop_front();
          check("dut2_instr_pc", instr_pc2, e.pc);
          check("dut2_instr", instr2, e.word);
        end
      end
      if (imem_req && !prev_req) req_count++;
      prev_req = imem_req;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    reset = 1'b1;  instr_ready = 1'b0;  redirect = 1'b0;  redirect_pc = 32'h0;
    instr_ready2 = 1'b0;  redirect2 = 1'b0;  redirect_pc2 = 32'h0;
    tick(3);

    // Reset state.
    @(negedge clock);
    check("rst_imem_req", 32'(imem_req), 32'h0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_instr_valid", 32'(instr_valid), 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_dut2_imem_addr", imem_addr2, 32'hFFFF_FFF8);

    // Streaming fetch from reset with the core always ready.
    q.push_back('{pc: 32'h0000_0000, word: 32'h1000_0000});
    q.push_back('{pc: 32'h0000_0004, word: 32'h1000_0001});
    q.push_back('{pc: 32'h0000_0008, word: 32'h1000_0002});
    q.push_back('{pc: 32'h0000_000C, word: 32'h1000_0003});
    tick(1);
    instr_ready = 1'b1;
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("first_req", 32'(imem_req), 32'h1);
    check("first_req_addr", imem_addr, 32'h0);
    drain(0, 40, "stream");

    // Core stalled: exactly FIFO_DEPTH requests, then the bus goes quiet.
    redirect = 1'b1;  redirect_pc = 32'h0000_0100;
    tick(1);
    redirect = 1'b0;
    req_count = 0;
    tick(20);
    check("full_req_count", 32'(req_count), 32'd4);
    check("full_imem_req", 32'(imem_req), 32'h0);
    q.push_back('{pc: 32'h0000_0100, word: 32'h1000_0040});
    q.push_back('{pc: 32'h0000_0104, word: 32'h1000_0041});
    q.push_back('{pc: 32'h0000_0108, word: 32'h1000_0042});
    q.push_back('{pc: 32'h0000_010C, word: 32'h1000_0043});
    drain(0, 40, "full_release");

    // Redirect while waiting; ack three cycles later is dropped.
    mem_stall = 1'b1;
    redirect = 1'b1;  redirect_pc = 32'h0000_0200;
    tick(1);
    redirect = 1'b0;
    wait_req(1'b1, "drop_req");
    check("drop_req_addr", imem_addr, 32'h0000_0200);
    redirect = 1'b1;  redirect_pc = 32'h0000_0043;
    tick(1);
    redirect = 1'b0;
    @(negedge clock);
    check("drop_valid", 32'(instr_valid), 32'h0);
    check("drop_hold_addr", imem_addr, 32'h0000_0200);
    tick(1);
    mem_stall = 1'b0;
    wait_req(1'b0, "drop_ack");
    wait_req(1'b1, "drop_next_req");
    check("drop_next_addr", imem_addr, 32'h0000_0040);
    q.push_back('{pc: 32'h0000_0040, word: 32'h1000_0010});
    drain(0, 40, "drop_deliver");

    // Redirect in the same cycle as the ack.
    mem_stall = 1'b1;
    redirect = 1'b1;  redirect_pc = 32'h0000_0300;
    tick(1);
    redirect = 1'b0;
    wait_req(1'b1, "same_req");
    mem_stall = 1'b0;
    tick(1);
    redirect = 1'b1;  redirect_pc = 32'h0000_0500;
    mem_stall = 1'b1;
    instr_ready = 1'b1;
    tick(1);
    redirect = 1'b0;
    @(negedge clock);
    check("same_valid", 32'(instr_valid), 32'h0);
    q.push_back('{pc: 32'h0000_0500, word: 32'h1000_0140});
    mem_stall = 1'b0;
    drain(0, 40, "same_deliver");

    // Reset mid-request, then a stray ack while idle must be ignored.
    mem_stall = 1'b1;
    wait_req(1'b1, "rst_mid_req");
    reset = 1'b1;
    #1;
    check("rst_mid_imem_req", 32'(imem_req), 32'h0);
    check("rst_mid_valid", 32'(instr_valid), 32'h0);
    check("rst_mid_addr", imem_addr, 32'h0);
    force_ack = 1'b1;
    mem_stall = 1'b0;
    tick(1);
    q.push_back('{pc: 32'h0000_0000, word: 32'h1000_0000});
    q.push_back('{pc: 32'h0000_0004, word: 32'h1000_0001});
    reset = 1'b0;
    force_ack = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("rst_restart_req", 32'(imem_req), 32'h1);
    check("rst_restart_addr", imem_addr, 32'h0);
    drain(0, 40, "rst_restart");

    // PC wrap on the second instance.
    q2.push_back('{pc: 32'hFFFF_FFF8, word: 32'h0000_0007});
    q2.push_back('{pc: 32'hFFFF_FFFC, word: 32'h0000_0003});
    q2.push_back('{pc: 32'h0000_0000, word: 32'hFFFF_FFFF});
    drain(1, 40, "wrap");

`ifdef FETCH_STATS_EN
    // Stall counter: ready from reset, first ack five cycles out.
    begin
      bit seen = 1'b0;
      reset = 1'b1;
      ack_delay = 4;
      q.push_back('{pc: 32'h0000_0000, word: 32'h1000_0000});
      instr_ready = 1'b1;
      tick(1);
      reset = 1'b0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clock);
        if (instr_valid) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) begin
        vectors++;
        errors++;
        $display("FAIL stats_valid: instr_valid got 0, expected 1");
      end
      check("stall_count", stall_count, 32'd6);
      tick(1);
      instr_ready = 1'b0;
      ack_delay = 0;
    end
`endif

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mips_fetch_unit.md
MIPS_FETCH_UNIT -- requirements
Module: mips_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000: first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: prefetch buffer entries; legal values are 2, 4 or 8.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clock, input, 1: sole clock, all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous active-high reset.
REQ-006 SHALL have port imem_req, output, 1: instruction-memory read request.
REQ-007 SHALL have port imem_addr, output, 32: byte address of the request, word-aligned.
REQ-008 SHALL have port imem_ack, input, 1: read complete; imem_rdata is valid this cycle.
REQ-009 SHALL have port imem_rdata, input, 32: instruction word returned.
REQ-010 SHALL have port instr_valid, output, 1: instr and instr_pc hold a fetched instruction.
REQ-011 SHALL have port instr, output, 32: instruction word delivered to the core.
REQ-012 SHALL have port instr_pc, output, 32: byte address of instr.
REQ-013 SHALL have port instr_ready, input, 1: the core consumes instr this cycle.
REQ-014 SHALL have port redirect, input, 1: branch or jump taken; discard all prefetched instructions.
REQ-015 SHALL have port redirect_pc, input, 32: new fetch address, valid while redirect=1.

Function
REQ-016 SHALL implement a state machine with states IDLE, WAIT and DROP.
REQ-017 SHALL be in IDLE with no request outstanding; WAIT with a request outstanding whose data will be kept; DROP with a request outstanding whose data will be discarded.
REQ-018 SHALL move IDLE->WAIT by asserting imem_req=1 with imem_addr=fetch_pc, only when FIFO occupancy < FIFO_DEPTH and redirect=0.
REQ-019 SHALL hold imem_req and imem_addr stable in WAIT and DROP until the imem_ack cycle; only one request is ever outstanding.
REQ-020 SHALL, on imem_ack in WAIT with redirect=0, push {fetch_pc, imem_rdata} into the FIFO, set fetch_pc to fetch_pc+4, and return to IDLE.
REQ-021 SHALL let fetch_pc+4 wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-022 SHALL drive instr_valid=1 exactly when the FIFO is non-empty, with instr and instr_pc taken from the head entry.
REQ-023 SHALL pop the head entry on a cycle where instr_valid=1 and instr_ready=1.
REQ-024 SHALL support push and pop in the same cycle, leaving occupancy unchanged.
REQ-025 SHALL deliver instructions in address order; latency from imem_ack to instr_valid=1 on an empty FIFO is 1 cycle.
REQ-026 SHALL give redirect priority over push, pop and issue; on redirect=1, the FIFO is emptied and fetch_pc is set to {redirect_pc[31:2],2'b00} at the next edge.
REQ-027 SHALL, if redirect=1 in WAIT without imem_ack, enter DROP.
REQ-028 SHALL, on imem_ack in DROP, discard the data and return to IDLE; a redirect during DROP only updates fetch_pc.
REQ-029 SHALL, if redirect=1 in the same cycle as imem_ack, discard the acked data, go to IDLE and leave fetch_pc at the redirect target.
REQ-030 SHALL hold instr_valid=0 in the cycle after a redirect.

Reset
REQ-031 SHALL, on reset assertion, immediately set state=IDLE, fetch_pc=RESET_PC, FIFO empty, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
REQ-032 SHALL, on reset mid-request, abandon the outstanding request and ignore any later imem_ack that arrives while in IDLE.
REQ-033 SHALL issue the first request in the first clock cycle after reset deasserts.

Configuration
REQ-034 SHALL, with FETCH_STATS_EN defined, add output stall_count (32 bits), reset to 0, which increments in each cycle where instr_ready=1 and instr_valid=0, saturating at 32'hFFFFFFFF.
REQ-035 SHALL, without FETCH_STATS_EN defined, have no stall_count port and no counter logic.

Verification
REQ-036 SHALL cover: reset, imem_ack one cycle after each request, memory word n = 32'h1000_0000+n, instr_ready=1 -> instr_pc sequence 0,4,8,12 with matching words, no gaps after the first.
REQ-037 SHALL cover: instr_ready=0 for 20 cycles -> exactly FIFO_DEPTH (4) requests issued, imem_req=0 afterward, and no data loss once ready rises.
REQ-038 SHALL cover: redirect=1 with redirect_pc=32'h0000_0043 while in WAIT, ack 3 cycles later -> acked data dropped, next imem_addr=32'h0000_0040, and the first delivered instr_pc=32'h40.
REQ-039 SHALL cover: redirect in the same cycle as imem_ack -> acked word never delivered, and instr_valid=0 in the next cycle.
REQ-040 SHALL cover: RESET_PC=32'hFFFF_FFF8 -> delivered PCs FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-041 SHALL cover: with FETCH_STATS_EN, instr_ready=1 and ack delayed by 5 cycles from reset -> stall_count=6 when the first instr_valid=1.
